// File: rtl/sdram_local_arbiter_if.sv
// Channel-side and controller-side signal bundle for the SDRAM local arbiter.
// The master modport is the arbiter's view; slave is the surrounding fabric.
interface sdram_local_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8,
    parameter int SIZE_W = 3
);
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH-1:0]        ch_read_req;
    logic [NUM_CH-1:0]        ch_write_req;
    logic [NUM_CH*SIZE_W-1:0] ch_size;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH*BE_W-1:0]   ch_be;
    logic [NUM_CH-1:0]        ch_ready;
    logic [DATA_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_rdata_valid;

    logic [ADDR_W-1:0]        local_address;
    logic [SIZE_W-1:0]        local_size;
    logic [DATA_W-1:0]        local_wdata;
    logic [BE_W-1:0]          local_be;
    logic                     local_read_req;
    logic                     local_write_req;
    logic                     local_burstbegin;
    logic                     local_ready;
    logic                     local_init_done;
    logic                     local_rdata_valid;
    logic [DATA_W-1:0]        local_rdata;

    modport master (
        input  ch_address, ch_read_req, ch_write_req, ch_size, ch_wdata, ch_be,
        output ch_ready, ch_rdata, ch_rdata_valid,
        output local_address, local_size, local_wdata, local_be,
        output local_read_req, local_write_req, local_burstbegin,
        input  local_ready, local_init_done, local_rdata_valid, local_rdata
    );

    modport slave (
        output ch_address, ch_read_req, ch_write_req, ch_size, ch_wdata, ch_be,
        input  ch_ready, ch_rdata, ch_rdata_valid,
        input  local_address, local_size, local_wdata, local_be,
        input  local_read_req, local_write_req, local_burstbegin,
        output local_ready, local_init_done, local_rdata_valid, local_rdata
    );
endinterface

// File: rtl/sdram_local_arbiter.sv
// Round-robin N-channel front end for the DDR controller local port: locks the
// grant across write bursts and tags reads so returning data reaches its issuer.
module sdram_local_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int SIZE_W    = 3,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         i_phy_clk,
    input  logic                         i_reset_phy_clk,
    sdram_local_arbiter_if.master        bus,
    output logic [$clog2(TAG_DEPTH):0]   o_rd_outstanding,
    output logic                         o_err_orphan_rdata
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam logic [PTR_W:0]      FULL_CNT = (PTR_W + 1)'(TAG_DEPTH);
    localparam logic [SIZE_W-1:0]   ONE_BEAT = SIZE_W'(1);

    typedef enum logic {IDLE, WR_BURST} state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_grant;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [SIZE_W-1:0]   r_beats_left;
    logic [CH_W-1:0]     r_tag_ch    [TAG_DEPTH];
    logic [SIZE_W-1:0]   r_tag_beats [TAG_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic                r_err;

    logic [NUM_CH-1:0]   w_elig;
    logic                w_found;
    logic [CH_W-1:0]     w_sel;
    logic [CH_W-1:0]     w_next;
    logic [SIZE_W-1:0]   w_size;
    logic                w_is_write;
    logic                w_is_read;
    logic                w_req;
    logic                w_fwd;
    logic                w_accept;
    logic                w_push;
    logic                w_empty;
    logic                w_rvalid;
    logic                w_pop;

    assign w_elig = bus.ch_read_req | bus.ch_write_req;

    // During a burst the locked grant is the only candidate; otherwise search from rr_ptr with wrap.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_grant;
        if (r_state == IDLE) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NUM_CH]) begin
                    w_found = 1'b1;
                    w_sel   = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
                end
            end
        end
    end

    always_comb begin
        w_size = bus.ch_size[int'(w_sel)*SIZE_W +: SIZE_W];
        if (w_size == '0) begin
            w_size = ONE_BEAT;
        end
        w_is_write = bus.ch_write_req[w_sel];
        w_is_read  = (r_state == IDLE) && !w_is_write && bus.ch_read_req[w_sel];
        w_req      = (r_state == IDLE) ? w_found : w_is_write;
        w_fwd      = w_req && !i_reset_phy_clk && bus.local_init_done &&
                     (!w_is_read || (r_count < FULL_CNT));
        w_accept   = w_fwd && bus.local_ready;
        w_push     = w_accept && w_is_read;
        w_next     = (int'(w_sel) == NUM_CH - 1) ? '0 : w_sel + CH_W'(1);
    end

    assign w_empty  = (r_count == '0);
    assign w_rvalid = bus.local_rdata_valid && !w_empty && !i_reset_phy_clk;
    assign w_pop    = w_rvalid && (r_tag_beats[r_rd_ptr] == ONE_BEAT);

    assign bus.local_address    = bus.ch_address[int'(w_sel)*ADDR_W +: ADDR_W];
    assign bus.local_wdata      = bus.ch_wdata[int'(w_sel)*DATA_W +: DATA_W];
    assign bus.local_be         = bus.ch_be[int'(w_sel)*BE_W +: BE_W];
    assign bus.local_size       = w_size;
    assign bus.local_read_req   = w_fwd && w_is_read;
    assign bus.local_write_req  = w_fwd && w_is_write;
    assign bus.local_burstbegin = w_fwd && (w_is_read || (r_state == IDLE));
    assign bus.ch_ready         = w_accept ? (NUM_CH'(1) << w_sel) : '0;
    assign bus.ch_rdata         = bus.local_rdata;
    assign bus.ch_rdata_valid   = w_rvalid ? (NUM_CH'(1) << r_tag_ch[r_rd_ptr]) : '0;

    assign o_rd_outstanding   = i_reset_phy_clk ? '0 : r_count;
    assign o_err_orphan_rdata = r_err;

    always_ff @(posedge i_phy_clk) begin
        if (i_reset_phy_clk) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_beats_left <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_write && (w_size != ONE_BEAT)) begin
                            r_beats_left <= w_size - ONE_BEAT;
                            r_grant      <= w_sel;
                            r_state      <= WR_BURST;
                        end else begin
                            r_rr_ptr <= w_next;
                        end
                    end
                end
                WR_BURST: begin
                    if (w_accept) begin
                        r_beats_left <= r_beats_left - ONE_BEAT;
                        if (r_beats_left == ONE_BEAT) begin
                            r_rr_ptr <= w_next;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.local_rdata_valid && w_empty) r_err <= 1'b1;
        end
    end

    // Push never targets the head slot while it is live, so the in-place countdown cannot collide.
    always_ff @(posedge i_phy_clk) begin
        if (w_push) begin
            r_tag_ch[r_wr_ptr]    <= w_sel;
            r_tag_beats[r_wr_ptr] <= w_size;
        end
        if (w_rvalid && !w_pop) begin
            r_tag_beats[r_rd_ptr] <= r_tag_beats[r_rd_ptr] - ONE_BEAT;
        end
    end
endmodule

// File: tb/tb_sdram_local_arbiter.sv
// Directed bench for sdram_local_arbiter: reset, round-robin, burst lock,
// backpressure, tag-FIFO fullness, orphan read data and reset mid-burst.
module tb_sdram_local_arbiter;
    localparam int NUM_CH    = 2;
    localparam int ADDR_W    = 23;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int SIZE_W    = 3;
    localparam int TAG_DEPTH = 8;

    logic       phyClk = 1'b0;
    logic       resetPhyClk;
    logic [3:0] rdOutstanding;
    logic       errOrphan;
    int         assertCount = 0;
    int         failCount   = 0;

    sdram_local_arbiter_if #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .SIZE_W(SIZE_W)
    ) bus ();

    sdram_local_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .SIZE_W(SIZE_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .i_phy_clk(phyClk),
        .i_reset_phy_clk(resetPhyClk),
        .bus(bus),
        .o_rd_outstanding(rdOutstanding),
        .o_err_orphan_rdata(errOrphan)
    );

    always #5 phyClk = ~phyClk;

    task automatic applyStimulus(input int ch, input logic rd, input logic wr,
                                 input logic [2:0] size, input logic [22:0] addr,
                                 input logic [31:0] data);
        bus.ch_read_req[ch]             = rd;
        bus.ch_write_req[ch]            = wr;
        bus.ch_size[ch*SIZE_W +: SIZE_W] = size;
        bus.ch_address[ch*ADDR_W +: ADDR_W] = addr;
        bus.ch_wdata[ch*DATA_W +: DATA_W] = data;
        bus.ch_be[ch*BE_W +: BE_W]      = 4'hF;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge phyClk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    initial begin
        resetPhyClk = 1'b1;
        bus.ch_read_req = '0; bus.ch_write_req = '0; bus.ch_size = '0;
        bus.ch_address = '0; bus.ch_wdata = '0; bus.ch_be = '0;
        bus.local_ready = 1'b1; bus.local_init_done = 1'b1;
        bus.local_rdata_valid = 1'b0; bus.local_rdata = '0;

        // Reset holds every output low even with live requests
        applyStimulus(0, 1, 0, 1, 23'h10, 0);
        applyStimulus(1, 1, 0, 1, 23'h20, 0);
        bus.local_rdata_valid = 1'b1;
        tick; tick; settle;
        checkOutput("rst_ch_ready", bus.ch_ready, 0);
        checkOutput("rst_rd_req", bus.local_read_req, 0);
        checkOutput("rst_wr_req", bus.local_write_req, 0);
        checkOutput("rst_bb", bus.local_burstbegin, 0);
        checkOutput("rst_rvalid", bus.ch_rdata_valid, 0);
        checkOutput("rst_outstanding", rdOutstanding, 0);
        checkOutput("rst_err", errOrphan, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        bus.local_rdata_valid = 1'b0;
        resetPhyClk = 1'b0;
        tick;

        // No forwarding before controller init
        bus.local_init_done = 1'b0;
        applyStimulus(0, 1, 0, 2, 23'h100, 0);
        settle;
        checkOutput("init_rd_req", bus.local_read_req, 0);
        checkOutput("init_ch_ready", bus.ch_ready, 0);
        tick; settle;
        checkOutput("init_outstanding", rdOutstanding, 0);

        // Single read, size 2
        bus.local_init_done = 1'b1;
        settle;
        checkOutput("rd_req", bus.local_read_req, 1);
        checkOutput("rd_bb", bus.local_burstbegin, 1);
        checkOutput("rd_addr", bus.local_address, 32'h100);
        checkOutput("rd_size", bus.local_size, 2);
        checkOutput("rd_ch_ready", bus.ch_ready, 2'b01);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0);
        settle;
        checkOutput("rd_outstanding_1", rdOutstanding, 1);
        bus.local_rdata_valid = 1'b1; bus.local_rdata = 32'hA5A50001;
        settle;
        checkOutput("rd_beat1_valid", bus.ch_rdata_valid, 2'b01);
        checkOutput("rd_beat1_data", bus.ch_rdata, 32'hA5A50001);
        tick;
        bus.local_rdata = 32'hA5A50002;
        settle;
        checkOutput("rd_beat2_valid", bus.ch_rdata_valid, 2'b01);
        checkOutput("rd_beat2_outstanding", rdOutstanding, 1);
        tick;
        bus.local_rdata_valid = 1'b0;
        settle;
        checkOutput("rd_outstanding_0", rdOutstanding, 0);

        // Round-robin: rr_ptr is 1 after the ch0 read, so grants go 1,0,1,0
        applyStimulus(0, 1, 0, 1, 23'h10, 0);
        applyStimulus(1, 1, 0, 1, 23'h20, 0);
        for (int i = 0; i < 4; i++) begin
            settle;
            checkOutput("rr_ready", bus.ch_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
            checkOutput("rr_addr", bus.local_address, (i % 2 == 0) ? 32'h20 : 32'h10);
            tick;
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        settle;
        checkOutput("rr_outstanding_4", rdOutstanding, 4);
        bus.local_rdata_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle;
            checkOutput("rr_return", bus.ch_rdata_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick;
        end
        bus.local_rdata_valid = 1'b0;
        settle;
        checkOutput("rr_outstanding_0", rdOutstanding, 0);

        // Size 0 is one beat
        applyStimulus(0, 1, 0, 0, 23'h30, 0);
        settle;
        checkOutput("sz0_size", bus.local_size, 1);
        checkOutput("sz0_ready", bus.ch_ready, 2'b01);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0);
        bus.local_rdata_valid = 1'b1;
        settle;
        checkOutput("sz0_return", bus.ch_rdata_valid, 2'b01);
        tick;
        bus.local_rdata_valid = 1'b0;
        settle;
        checkOutput("sz0_outstanding", rdOutstanding, 0);

        // Write burst lock on ch1 with ch0 reading, plus 3 cycles of backpressure
        applyStimulus(1, 0, 1, 4, 23'h200, 32'hD0000001);
        applyStimulus(0, 1, 0, 1, 23'h40, 0);
        settle;
        checkOutput("wb1_ready", bus.ch_ready, 2'b10);
        checkOutput("wb1_wr_req", bus.local_write_req, 1);
        checkOutput("wb1_rd_req", bus.local_read_req, 0);
        checkOutput("wb1_bb", bus.local_burstbegin, 1);
        checkOutput("wb1_data", bus.local_wdata, 32'hD0000001);
        checkOutput("wb1_size", bus.local_size, 4);
        tick;
        applyStimulus(1, 0, 1, 4, 23'h200, 32'hD0000002);
        settle;
        checkOutput("wb2_ready", bus.ch_ready, 2'b10);
        checkOutput("wb2_bb", bus.local_burstbegin, 0);
        checkOutput("wb2_data", bus.local_wdata, 32'hD0000002);
        tick;
        applyStimulus(1, 0, 1, 4, 23'h200, 32'hD0000003);
        bus.local_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle;
            checkOutput("bp_ready", bus.ch_ready, 0);
            checkOutput("bp_wr_req", bus.local_write_req, 1);
            checkOutput("bp_data", bus.local_wdata, 32'hD0000003);
            checkOutput("bp_addr", bus.local_address, 32'h200);
            tick;
        end
        bus.local_ready = 1'b1;
        settle;
        checkOutput("wb3_ready", bus.ch_ready, 2'b10);
        tick;
        applyStimulus(1, 0, 1, 4, 23'h200, 32'hD0000004);
        settle;
        checkOutput("wb4_ready", bus.ch_ready, 2'b10);
        checkOutput("wb4_bb", bus.local_burstbegin, 0);
        tick;
        applyStimulus(1, 0, 1, 1, 23'h204, 32'hD0000005);
        settle;
        checkOutput("post_burst_ready", bus.ch_ready, 2'b01);
        checkOutput("post_burst_rd_req", bus.local_read_req, 1);
        checkOutput("post_burst_addr", bus.local_address, 32'h40);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0);
        settle;
        checkOutput("wr1_ready", bus.ch_ready, 2'b10);
        checkOutput("wr1_bb", bus.local_burstbegin, 1);
        checkOutput("wr1_size", bus.local_size, 1);
        tick;
        applyStimulus(1, 0, 0, 0, 0, 0);
        bus.local_rdata_valid = 1'b1;
        settle;
        checkOutput("wb_rd_return", bus.ch_rdata_valid, 2'b01);
        tick;
        bus.local_rdata_valid = 1'b0;

        // Write beats read when a channel asserts both
        applyStimulus(0, 1, 1, 1, 23'h50, 32'hE0000000);
        settle;
        checkOutput("prec_wr_req", bus.local_write_req, 1);
        checkOutput("prec_rd_req", bus.local_read_req, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0);
        settle;
        checkOutput("prec_outstanding", rdOutstanding, 0);

        // Tag FIFO full: eight reads accepted, ninth stalls until a pop registers
        applyStimulus(0, 1, 0, 1, 23'h60, 0);
        for (int i = 0; i < 8; i++) begin
            settle;
            checkOutput("fill_ready", bus.ch_ready, 2'b01);
            tick;
        end
        settle;
        checkOutput("full_outstanding", rdOutstanding, 8);
        checkOutput("full_ready", bus.ch_ready, 0);
        checkOutput("full_rd_req", bus.local_read_req, 0);
        tick;
        bus.local_rdata_valid = 1'b1;
        settle;
        checkOutput("full_pop_ready", bus.ch_ready, 0);
        checkOutput("full_pop_valid", bus.ch_rdata_valid, 2'b01);
        tick;
        settle;
        checkOutput("pushpop_ready", bus.ch_ready, 2'b01);
        checkOutput("pushpop_pre", rdOutstanding, 7);
        tick;
        bus.local_rdata_valid = 1'b0;
        settle;
        checkOutput("pushpop_post", rdOutstanding, 7);
        checkOutput("refill_ready", bus.ch_ready, 2'b01);
        tick;
        settle;
        checkOutput("refull_outstanding", rdOutstanding, 8);
        checkOutput("refull_ready", bus.ch_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        bus.local_rdata_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle;
            checkOutput("drain_valid", bus.ch_rdata_valid, 2'b01);
            tick;
        end
        bus.local_rdata_valid = 1'b0;
        settle;
        checkOutput("drain_outstanding", rdOutstanding, 0);
        checkOutput("drain_err", errOrphan, 0);

        // Orphan read data is dropped and flagged stickily
        bus.local_rdata_valid = 1'b1;
        settle;
        checkOutput("orphan_valid", bus.ch_rdata_valid, 0);
        tick;
        bus.local_rdata_valid = 1'b0;
        settle;
        checkOutput("orphan_err", errOrphan, 1);
        tick; settle;
        checkOutput("orphan_sticky", errOrphan, 1);

        // Reset mid-burst abandons the burst and restores rr_ptr to 0
        applyStimulus(1, 0, 1, 4, 23'h300, 32'hF1);
        settle;
        checkOutput("rb_beat1_ready", bus.ch_ready, 2'b10);
        tick;
        resetPhyClk = 1'b1;
        settle;
        checkOutput("rb_ready", bus.ch_ready, 0);
        checkOutput("rb_wr_req", bus.local_write_req, 0);
        checkOutput("rb_bb", bus.local_burstbegin, 0);
        tick;
        resetPhyClk = 1'b0;
        applyStimulus(1, 1, 0, 1, 23'h74, 0);
        applyStimulus(0, 1, 0, 1, 23'h70, 0);
        settle;
        checkOutput("rb_err_clr", errOrphan, 0);
        checkOutput("rb_outstanding", rdOutstanding, 0);
        checkOutput("rb_idle_ready", bus.ch_ready, 2'b01);
        checkOutput("rb_idle_rd_req", bus.local_read_req, 1);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
